score_hud: RTL and testbench
============================

# score_hud

Seven-segment heads-up display stage that sits directly downstream of the game controller and consumes its `score`, `lives` and `game_over` outputs. It converts the 16-bit binary score (or the stored high score) to five BCD digits with an iterative shift-add-3 converter, drives six active-low seven-segment displays, and tracks the session high score. While the game is over it alternates between the final score and the high score.

## Interface
Parameters:
- `TOGGLE_CYCLES`, 50_000_000: clock cycles per score/high-score alternation during game over (1 s at 50 MHz).

Ports:
- `clk` input 1: the block's single clock; all logic is on its rising edge.
- `reset` input 1: synchronous, active-high reset.
- `score` input 16: current score from the game controller, unsigned.
- `lives` input 3: remaining lives, 0–7.
- `game_over` input 1: level, high while the game is over.
- `hex0`..`hex4` output 7 each: score digits, units to ten-thousands, active-low, bit6=g … bit0=a.
- `hex5` output 7: lives digit, or letter H while the high score is shown.
- `high_score` output 16: best score this power-up/reset.
- `new_record` output 1: high while the current game-over score set a new high score.
- `busy` output 1: converter running.

## Operation
- Source select: `src = show_high ? high_score : score`. `show_high` is 0 whenever `game_over`=0.
- Converter FSM states: IDLE, SHIFT, DONE.
  - IDLE: if `src != last_conv`, capture `src` into a 16-bit shift register, set `last_conv <= src`, clear the 5×4-bit BCD accumulator and the 4-bit step counter, and go to SHIFT.
  - SHIFT: each cycle add 3 to every BCD nibble ≥5, then shift {BCD, bin} left by 1. After 16 steps go to DONE.
  - DONE: commit the BCD result to the display registers, then return to IDLE.
- Changes to `src` during SHIFT or DONE do not disturb the conversion in progress. The mismatch is seen in the next IDLE cycle and triggers a fresh conversion.
- Leading-zero blanking: digits above the most significant nonzero digit show 7'h7F. `hex0` is always lit, so 0 displays as "0".
- Segment codes: 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000, H=0001001, blank=1111111.
- `hex5` is a register updated every cycle: H if `show_high`, else the digit code for `lives`.
- High score: on the rising edge of `game_over` (`game_over & ~game_over_q`), if `score > high_score`, load `high_score <= score` and set `new_record <= 1`. `new_record` clears on the falling edge of `game_over`. Equal scores do not set a record.
- Alternation: on the rising edge of `game_over`, clear the toggle counter and set `show_high <= 0`. While `game_over`=1, the counter counts to TOGGLE_CYCLES-1, then wraps to 0 and inverts `show_high`. On the falling edge of `game_over`, clear `show_high` and the counter.

## Timing
- Reset values:
  - state IDLE, `busy`=0.
  - `last_conv`=0, `high_score`=0, `new_record`=0, `show_high`=0, counter 0.
  - `hex0`=1000000, `hex1`..`hex4`=1111111, `hex5`=1111111.
- The first cycle after reset loads `hex5` from `lives`.
- Reset mid-conversion aborts the conversion and returns all outputs to the reset values above.
- Latency: if `src` changes before edge N while in IDLE, capture happens at edge N. Shift steps occur at edges N+1..N+16, the commit at edge N+17, and `hex0`..`hex4` are visible after edge N+17.
- `busy`=1 from edge N through edge N+16.
- Back-to-back: the earliest next capture is edge N+18.
- `hex5` latency is 1 cycle from `lives` or `show_high`.
- `high_score` and `new_record` latency is 1 cycle from the registered `game_over` edge, i.e. they update at the edge after the rising edge is detected.
- Arithmetic: unsigned throughout. 65535 converts to 6,5,5,3,5 with no overflow. The step counter wraps 15→0 on the exit to DONE.

## Structure
- Shared package `hud_pkg`:
  - converter state enum `conv_state_t`.
  - seven-segment localparams (digits, H, BLANK).
  - function `seg7(input [3:0])`.
- Sub-module `bin2bcd_seq` holds the FSM, shift register, step counter and `busy`:
  - inputs: `start`, `bin[15:0]`.
  - outputs: `bcd[19:0]`, `done` pulse.
- `score_hud` holds the trigger compare, blanking, high-score logic, toggle counter and output registers.

## Test plan
- Reset, then `score`=0, `lives`=3 → `hex0`=1000000, `hex1`..`hex4` blank, `hex5`=0110000 after one cycle, `busy`=0.
- `score` 0→1234 → `busy` high for 17 cycles. Eighteen cycles after the change, digits read 4,3,2,1 and `hex4` is blank.
- `score`=65535 → digits 5,3,5,5,6 with all five lit. Change `score` to 7 during SHIFT → 65535 is committed first, then 7 is committed 18 cycles later with `hex1`..`hex4` blank.
- `score`=42, `game_over` rises (TOGGLE_CYCLES=4 in the bench) → `high_score`=42 and `new_record`=1. After 4 cycles `hex5`=H and the display converts 42. Repeat with `score`=42 again → `new_record` stays 0.
- `game_over` falls → `new_record`=0 and `show_high`=0 on the next edge, `hex5` shows lives, and the score source is restored.
- Assert `reset` mid-SHIFT → next cycle all outputs hold their reset values and `high_score`=0.

Source files
------------

// File: rtl/hud_pkg.sv
// Shared types, seven-segment codes and digit encoder for the score HUD.
package hud_pkg;

    localparam int unsigned BIN_W  = 16;
    localparam int unsigned DIGITS = 5;
    localparam int unsigned BCD_W  = 4 * DIGITS;
    localparam int unsigned SEG_W  = 7;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SHIFT,
        ST_DONE
    } conv_state_t;

    // Active-low segments, bit6=g ... bit0=a
    localparam logic [SEG_W-1:0] SEG_0     = 7'b1000000;
    localparam logic [SEG_W-1:0] SEG_1     = 7'b1111001;
    localparam logic [SEG_W-1:0] SEG_2     = 7'b0100100;
    localparam logic [SEG_W-1:0] SEG_3     = 7'b0110000;
    localparam logic [SEG_W-1:0] SEG_4     = 7'b0011001;
    localparam logic [SEG_W-1:0] SEG_5     = 7'b0010010;
    localparam logic [SEG_W-1:0] SEG_6     = 7'b0000010;
    localparam logic [SEG_W-1:0] SEG_7     = 7'b1111000;
    localparam logic [SEG_W-1:0] SEG_8     = 7'b0000000;
    localparam logic [SEG_W-1:0] SEG_9     = 7'b0010000;
    localparam logic [SEG_W-1:0] SEG_H     = 7'b0001001;
    localparam logic [SEG_W-1:0] SEG_BLANK = 7'b1111111;

    function automatic logic [SEG_W-1:0] seg7(input logic [3:0] d);
        case (d)
            4'd0:    return SEG_0;
            4'd1:    return SEG_1;
            4'd2:    return SEG_2;
            4'd3:    return SEG_3;
            4'd4:    return SEG_4;
            4'd5:    return SEG_5;
            4'd6:    return SEG_6;
            4'd7:    return SEG_7;
            4'd8:    return SEG_8;
            4'd9:    return SEG_9;
            default: return SEG_BLANK;
        endcase
    endfunction

endpackage

// File: rtl/bin2bcd_seq.sv
// Iterative shift-add-3 converter: 16-bit binary to five BCD digits in 16 steps.
module bin2bcd_seq
    import hud_pkg::*;
(
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [BIN_W-1:0] bin,
    output logic [BCD_W-1:0] bcd,
    output logic             done,
    output logic             busy
);

    conv_state_t              state_q;
    logic [BIN_W-1:0]         bin_q;
    logic [BCD_W-1:0]         bcd_q;
    logic [3:0]               step_q;
    logic                     busy_q;
    logic                     done_q;
    logic [BCD_W-1:0]         bcd_adj;
    logic [BCD_W+BIN_W-1:0]   shifted;

    // Correct every nibble that would overflow past 9 after the next doubling
    always_comb begin
        bcd_adj = bcd_q;
        for (int i = 0; i < int'(DIGITS); i++) begin
            if (bcd_q[4*i +: 4] >= 4'd5) begin
                bcd_adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
            end
        end
        shifted = {bcd_adj, bin_q} << 1;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            bin_q   <= '0;
            bcd_q   <= '0;
            step_q  <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        bin_q   <= bin;
                        bcd_q   <= '0;
                        step_q  <= '0;
                        busy_q  <= 1'b1;
                        state_q <= ST_SHIFT;
                    end
                end
                ST_SHIFT: begin
                    {bcd_q, bin_q} <= shifted;
                    step_q         <= step_q + 4'd1;
                    if (step_q == 4'd15) begin
                        done_q  <= 1'b1;
                        state_q <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    busy_q  <= 1'b0;
                    state_q <= ST_IDLE;
                end
                default: begin
                    busy_q  <= 1'b0;
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign bcd  = bcd_q;
    assign done = done_q;
    assign busy = busy_q;

endmodule

// File: rtl/score_hud.sv
// Seven-segment score HUD: BCD conversion trigger, blanking, high score and
// score/high-score alternation while the game is over.
module score_hud
    import hud_pkg::*;
#(
    parameter int unsigned TOGGLE_CYCLES = 50_000_000
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [BIN_W-1:0] score,
    input  logic [2:0]       lives,
    input  logic             game_over,
    output logic [SEG_W-1:0] hex0,
    output logic [SEG_W-1:0] hex1,
    output logic [SEG_W-1:0] hex2,
    output logic [SEG_W-1:0] hex3,
    output logic [SEG_W-1:0] hex4,
    output logic [SEG_W-1:0] hex5,
    output logic [BIN_W-1:0] high_score,
    output logic             new_record,
    output logic             busy
);

    localparam int unsigned CNT_W = (TOGGLE_CYCLES > 1) ? $clog2(TOGGLE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TOGGLE_CYCLES - 1);

    logic [BIN_W-1:0] last_conv_q;
    logic [BIN_W-1:0] high_score_q;
    logic             new_record_q;
    logic             show_high_q;
    logic             game_over_q;
    logic [CNT_W-1:0] tcnt_q;
    logic [SEG_W-1:0] hex_q [DIGITS];
    logic [SEG_W-1:0] hex5_q;

    logic [SEG_W-1:0] hex_d [DIGITS];
    logic [SEG_W-1:0] hex5_d;
    logic [3:0]       digit [DIGITS];
    logic             lit;
    logic [BIN_W-1:0] src_c;
    logic             start_c;
    logic             conv_busy;
    logic             conv_done;
    logic [BCD_W-1:0] conv_bcd;
    logic             rise_c;

    assign src_c   = show_high_q ? high_score_q : score;
    assign start_c = !conv_busy && (src_c != last_conv_q);
    assign rise_c  = game_over && !game_over_q;

    bin2bcd_seq u_conv (
        .clk   (clk),
        .reset (reset),
        .start (start_c),
        .bin   (src_c),
        .bcd   (conv_bcd),
        .done  (conv_done),
        .busy  (conv_busy)
    );

    // Blank every digit above the most significant nonzero one; units always lit
    always_comb begin
        for (int i = 0; i < int'(DIGITS); i++) begin
            digit[i] = conv_bcd[4*i +: 4];
        end
        hex_d[0] = seg7(digit[0]);
        lit      = 1'b0;
        for (int i = int'(DIGITS) - 1; i >= 1; i--) begin
            lit      = lit || (digit[i] != 4'd0);
            hex_d[i] = lit ? seg7(digit[i]) : SEG_BLANK;
        end
        hex5_d = show_high_q ? SEG_H : seg7({1'b0, lives});
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            last_conv_q  <= '0;
            high_score_q <= '0;
            new_record_q <= 1'b0;
            show_high_q  <= 1'b0;
            game_over_q  <= 1'b0;
            tcnt_q       <= '0;
            hex5_q       <= SEG_BLANK;
            hex_q[0]     <= SEG_0;
            for (int i = 1; i < int'(DIGITS); i++) begin
                hex_q[i] <= SEG_BLANK;
            end
        end else begin
            game_over_q <= game_over;
            hex5_q      <= hex5_d;

            if (start_c) begin
                last_conv_q <= src_c;
            end
            if (conv_done) begin
                for (int i = 0; i < int'(DIGITS); i++) begin
                    hex_q[i] <= hex_d[i];
                end
            end

            if (rise_c && (score > high_score_q)) begin
                high_score_q <= score;
                new_record_q <= 1'b1;
            end else if (!game_over && game_over_q) begin
                new_record_q <= 1'b0;
            end

            // Alternation restarts from the live score at every game-over entry
            if (!game_over || rise_c) begin
                tcnt_q      <= '0;
                show_high_q <= 1'b0;
            end else if (tcnt_q == CNT_LAST) begin
                tcnt_q      <= '0;
                show_high_q <= !show_high_q;
            end else begin
                tcnt_q <= tcnt_q + CNT_W'(1);
            end
        end
    end

    assign hex0       = hex_q[0];
    assign hex1       = hex_q[1];
    assign hex2       = hex_q[2];
    assign hex3       = hex_q[3];
    assign hex4       = hex_q[4];
    assign hex5       = hex5_q;
    assign high_score = high_score_q;
    assign new_record = new_record_q;
    assign busy       = conv_busy;

endmodule

// File: tb/tb_score_hud.sv
// Bench for score_hud: decimal-arithmetic reference model checked every cycle,
// plus directed literal checks at the interesting points.
module tb_score_hud;

    localparam int TC = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic [15:0] score;
    logic [2:0]  lives;
    logic        game_over;
    logic [6:0]  hex0, hex1, hex2, hex3, hex4, hex5;
    logic [15:0] high_score;
    logic        new_record;
    logic        busy;

    int total = 0;
    int bad   = 0;

    score_hud #(.TOGGLE_CYCLES(TC)) dut (
        .clk        (clk),
        .reset      (reset),
        .score      (score),
        .lives      (lives),
        .game_over  (game_over),
        .hex0       (hex0),
        .hex1       (hex1),
        .hex2       (hex2),
        .hex3       (hex3),
        .hex4       (hex4),
        .hex5       (hex5),
        .high_score (high_score),
        .new_record (new_record),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    localparam logic [6:0] S_H     = 7'b0001001;
    localparam logic [6:0] S_BLANK = 7'b1111111;

    function automatic logic [6:0] exp_seg(input int d);
        case (d)
            0: return 7'b1000000;
            1: return 7'b1111001;
            2: return 7'b0100100;
            3: return 7'b0110000;
            4: return 7'b0011001;
            5: return 7'b0010010;
            6: return 7'b0000010;
            7: return 7'b1111000;
            8: return 7'b0000000;
            9: return 7'b0010000;
            default: return S_BLANK;
        endcase
    endfunction

    // Digit k of value v, blank when v has no digit at position k (k>0)
    function automatic logic [6:0] exp_hex(input int v, input int k);
        int p;
        p = 1;
        for (int i = 0; i < k; i++) p = p * 10;
        if (k > 0 && v < p) return S_BLANK;
        return exp_seg((v / p) % 10);
    endfunction

    task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s at %0t: got=%0h want=%0h", nm, $time, act, exp);
        end
    endtask

    // Reference model: a conversion is a 17-cycle busy window ending with the value shown
    bit         m_valid = 1'b0;
    int         m_phase, m_last, m_pend, m_shown, m_hs, m_tcnt;
    bit         m_nr, m_show, m_go;
    logic [6:0] m_hex5;

    always @(posedge clk) begin
        int src;
        if (reset) begin
            m_valid = 1'b1;
            m_phase = 0; m_last = 0; m_pend = 0; m_shown = 0;
            m_hs = 0; m_tcnt = 0; m_nr = 0; m_show = 0; m_go = 0;
            m_hex5 = S_BLANK;
        end else begin
            src    = m_show ? m_hs : int'(score);
            m_hex5 = m_show ? S_H : exp_seg(int'(lives));
            if (m_phase == 0) begin
                if (src != m_last) begin
                    m_last  = src;
                    m_pend  = src;
                    m_phase = 17;
                end
            end else begin
                m_phase--;
                if (m_phase == 0) m_shown = m_pend;
            end
            if (game_over && !m_go) begin
                if (int'(score) > m_hs) begin
                    m_hs = int'(score);
                    m_nr = 1'b1;
                end
                m_tcnt = 0;
                m_show = 1'b0;
            end else if (game_over) begin
                m_tcnt++;
                if (m_tcnt == TC) begin
                    m_tcnt = 0;
                    m_show = !m_show;
                end
            end else begin
                if (m_go) m_nr = 1'b0;
                m_tcnt = 0;
                m_show = 1'b0;
            end
            m_go = game_over;
        end
    end

    always @(negedge clk) begin
        if (m_valid) begin
            chk("m_hex0", hex0, exp_hex(m_shown, 0));
            chk("m_hex1", hex1, exp_hex(m_shown, 1));
            chk("m_hex2", hex2, exp_hex(m_shown, 2));
            chk("m_hex3", hex3, exp_hex(m_shown, 3));
            chk("m_hex4", hex4, exp_hex(m_shown, 4));
            chk("m_hex5", hex5, m_hex5);
            chk("m_high_score", high_score, 16'(m_hs));
            chk("m_new_record", new_record, m_nr);
            chk("m_busy", busy, m_phase != 0);
        end
    end

    task automatic drive_slot();
        @(posedge clk);
        #2;
    endtask

    initial begin
        int nb;
        reset = 1'b1; score = 16'd0; lives = 3'd3; game_over = 1'b0;

        @(posedge clk); @(negedge clk);
        chk("rst_hex0", hex0, 7'b1000000);
        chk("rst_hex4", hex4, 7'b1111111);
        chk("rst_hex5", hex5, 7'b1111111);
        chk("rst_busy", busy, 1'b0);

        drive_slot(); reset = 1'b0;
        @(posedge clk); @(negedge clk);
        chk("lives3_hex5", hex5, 7'b0110000);
        chk("zero_hex0", hex0, 7'b1000000);
        chk("zero_hex1", hex1, 7'b1111111);

        drive_slot(); score = 16'd1234;
        nb = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (busy) nb++;
        end
        chk("busy_cycles", 16'(nb), 16'd17);
        chk("n1234_hex0", hex0, 7'b0011001);
        chk("n1234_hex1", hex1, 7'b0110000);
        chk("n1234_hex2", hex2, 7'b0100100);
        chk("n1234_hex3", hex3, 7'b1111001);
        chk("n1234_hex4", hex4, 7'b1111111);

        drive_slot(); score = 16'd65535;
        repeat (5) @(posedge clk);
        #2 score = 16'd7;
        repeat (13) @(posedge clk);
        @(negedge clk);
        chk("max_hex0", hex0, 7'b0010010);
        chk("max_hex1", hex1, 7'b0110000);
        chk("max_hex2", hex2, 7'b0010010);
        chk("max_hex3", hex3, 7'b0010010);
        chk("max_hex4", hex4, 7'b0000010);
        chk("max_busy", busy, 1'b0);
        repeat (18) @(posedge clk);
        @(negedge clk);
        chk("n7_hex0", hex0, 7'b1111000);
        chk("n7_hex1", hex1, 7'b1111111);
        chk("n7_hex4", hex4, 7'b1111111);

        drive_slot(); score = 16'd42;
        repeat (20) @(posedge clk);
        #2 game_over = 1'b1;
        @(posedge clk); @(negedge clk);
        chk("go1_high", high_score, 16'd42);
        chk("go1_record", new_record, 1'b1);
        repeat (5) @(posedge clk);
        @(negedge clk);
        chk("go1_hex5_H", hex5, 7'b0001001);
        chk("go1_hex0", hex0, 7'b0100100);
        chk("go1_hex1", hex1, 7'b0011001);

        drive_slot(); game_over = 1'b0;
        @(posedge clk); @(negedge clk);
        chk("fall_record", new_record, 1'b0);
        @(posedge clk); @(negedge clk);
        chk("fall_hex5", hex5, 7'b0110000);

        drive_slot(); game_over = 1'b1;
        @(posedge clk); @(negedge clk);
        chk("go2_record", new_record, 1'b0);
        chk("go2_high", high_score, 16'd42);
        repeat (10) @(posedge clk);
        #2 game_over = 1'b0;
        repeat (3) @(posedge clk);

        drive_slot(); score = 16'd100; lives = 3'd7;
        repeat (20) @(posedge clk);
        #2 game_over = 1'b1;
        @(posedge clk); @(negedge clk);
        chk("go3_high", high_score, 16'd100);
        chk("go3_record", new_record, 1'b1);
        repeat (6) @(posedge clk);
        #2 score = 16'd5;
        repeat (10) @(posedge clk);
        #2 game_over = 1'b0; lives = 3'd0;
        repeat (45) @(posedge clk);
        @(negedge clk);
        chk("n5_hex0", hex0, 7'b0010010);
        chk("n5_hex1", hex1, 7'b1111111);
        chk("lives0_hex5", hex5, 7'b1000000);

        drive_slot(); score = 16'd999;
        repeat (4) @(posedge clk);
        #2 reset = 1'b1;
        @(posedge clk); @(negedge clk);
        chk("mid_rst_busy", busy, 1'b0);
        chk("mid_rst_high", high_score, 16'd0);
        chk("mid_rst_record", new_record, 1'b0);
        chk("mid_rst_hex0", hex0, 7'b1000000);
        chk("mid_rst_hex1", hex1, 7'b1111111);
        chk("mid_rst_hex5", hex5, 7'b1111111);

        drive_slot(); reset = 1'b0;
        repeat (25) @(posedge clk);
        @(negedge clk);
        chk("n999_hex0", hex0, 7'b0010000);
        chk("n999_hex2", hex2, 7'b0010000);
        chk("n999_hex3", hex3, 7'b1111111);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
